pulse_stretch_tx: RTL and testbench

PULSE_STRETCH_TX -- requirements
Module: pulse_stretch_tx

---
 rtl/pulse_pkg.sv | 20 ++
 rtl/pulse_stretch_tx_if.sv | 30 +++
 rtl/pulse_pend_cnt.sv | 51 +++++
 rtl/pulse_stretch_tx.sv | 104 ++++++++++
 tb/tb_pulse_stretch_tx.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pulse_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | pulse_pkg : shared types and default constants for pulse_stretch |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package pulse_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam int c_HIGH_CYC_DEF = 20;
   localparam int c_LOW_CYC_DEF  = 20;
   localparam int c_PEND_W_DEF   = 4;
   localparam int c_CNT_W        = 8;

endpackage
`default_nettype wire

// File: rtl/pulse_stretch_tx_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | pulse_stretch_tx_if : event request / stretched pulse status bus |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
interface pulse_stretch_tx_if
   import pulse_pkg::*;
#(
   parameter int PEND_W = c_PEND_W_DEF
);

   logic              evt_in;
   logic              ovf_clr;
   logic              pulse_out;
   logic              busy;
   logic [PEND_W-1:0] pending;
   logic              overflow;

   modport master (
      output evt_in, ovf_clr,
      input  pulse_out, busy, pending, overflow
   );

   modport slave (
      input  evt_in, ovf_clr,
      output pulse_out, busy, pending, overflow
   );

endinterface
`default_nettype wire

// File: rtl/pulse_pend_cnt.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | pulse_pend_cnt : saturating up/down pending-event counter with   |
// | sticky overflow flag.                                  Rev 1.0    |
// +-------------------------------------------------------------------+
module pulse_pend_cnt #(
   parameter int PEND_W = 4
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              i_inc,
   input  wire logic              i_dec,
   input  wire logic              i_ovf_clr,
   output logic      [PEND_W-1:0] o_pending,
   output logic                   o_overflow
);

   logic [PEND_W-1:0] r_pending;
   logic              r_overflow;
   logic              w_full;
   logic              w_empty;
   logic              w_drop;

   assign w_full  = &r_pending;
   assign w_empty = (r_pending == '0);
   // A simultaneous inc/dec nets to zero, so only a lone inc can overflow.
   assign w_drop  = i_inc & ~i_dec & w_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending  <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (i_inc && !i_dec && !w_full) begin
            r_pending <= r_pending + 1'b1;
         end else if (i_dec && !i_inc && !w_empty) begin
            r_pending <= r_pending - 1'b1;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (i_ovf_clr) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign o_pending  = r_pending;
   assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/pulse_stretch_tx.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | pulse_stretch_tx : stretches single-cycle events into fixed-width |
// | pulses with guaranteed low gaps, queueing overlapping events.     |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module pulse_stretch_tx
   import pulse_pkg::*;
#(
   parameter int HIGH_CYC = c_HIGH_CYC_DEF,
   parameter int LOW_CYC  = c_LOW_CYC_DEF,
   parameter int PEND_W   = c_PEND_W_DEF
) (
   input wire logic          clk_fast,
   input wire logic          rst,
   pulse_stretch_tx_if.slave bus
);

   localparam logic [c_CNT_W-1:0] c_HIGH_LD = c_CNT_W'(HIGH_CYC - 1);
   localparam logic [c_CNT_W-1:0] c_LOW_LD  = c_CNT_W'(LOW_CYC - 1);

   state_t             r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_pulse;

   logic [PEND_W-1:0]  w_pending;
   logic               w_pend_nz;
   logic               w_cnt_zero;
   logic               w_want;
   logic               w_enter_high;
   logic               w_inc;
   logic               w_dec;

   assign w_pend_nz    = (w_pending != '0);
   assign w_cnt_zero   = (r_cnt == '0);
   assign w_want       = bus.evt_in | w_pend_nz;
   assign w_enter_high = w_want & ((r_state == IDLE) | ((r_state == LOW) & w_cnt_zero));

   // Queued events are older, so they are served first; a fresh event
   // bypasses the queue only when nothing is pending.
   assign w_dec = w_enter_high & w_pend_nz;
   assign w_inc = bus.evt_in & ~(w_enter_high & ~w_pend_nz);

   always_ff @(posedge clk_fast) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_enter_high) begin
                  r_state <= HIGH;
                  r_cnt   <= c_HIGH_LD;
                  r_pulse <= 1'b1;
               end
            end
            HIGH: begin
               if (w_cnt_zero) begin
                  r_state <= LOW;
                  r_cnt   <= c_LOW_LD;
                  r_pulse <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            LOW: begin
               if (!w_cnt_zero) begin
                  r_cnt <= r_cnt - 1'b1;
               end else if (w_enter_high) begin
                  r_state <= HIGH;
                  r_cnt   <= c_HIGH_LD;
                  r_pulse <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_pulse <= 1'b0;
            end
         endcase
      end
   end

   pulse_pend_cnt #(
      .PEND_W (PEND_W)
   ) u_pend (
      .clk        (clk_fast),
      .rst        (rst),
      .i_inc      (w_inc),
      .i_dec      (w_dec),
      .i_ovf_clr  (bus.ovf_clr),
      .o_pending  (w_pending),
      .o_overflow (bus.overflow)
   );

   assign bus.pulse_out = r_pulse;
   assign bus.pending   = w_pending;
   assign bus.busy      = (r_state != IDLE) | w_pend_nz;

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretch_tx.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_pulse_stretch_tx : directed self-checking bench for the pulse |
// | stretcher, with a divide-by-10 slow receiver model.    Rev 1.0    |
// +-------------------------------------------------------------------+
module tb_pulse_stretch_tx;

   localparam int HIGH_CYC = 20;
   localparam int LOW_CYC  = 20;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   t;
   int   nhigh;

   pulse_stretch_tx_if #(.PEND_W(4)) bus ();

   pulse_stretch_tx #(
      .HIGH_CYC (HIGH_CYC),
      .LOW_CYC  (LOW_CYC),
      .PEND_W   (4)
   ) dut (
      .clk_fast (clk),
      .rst      (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Slow receiver: samples pulse_out once every 10 fast cycles.
   bit slow_en = 1'b1;
   int sdiv = 0, srun = 0, slow_pulses = 0, min_run = 1000;
   always @(negedge clk) begin
      if (slow_en) begin
         if (sdiv == 9) begin
            sdiv = 0;
            if (bus.pulse_out) begin
               srun++;
            end else if (srun > 0) begin
               slow_pulses++;
               if (srun < min_run) min_run = srun;
               srun = 0;
            end
         end else begin
            sdiv++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Follows the pulse train from inside a high pulse until the block idles.
   task automatic watch(input int init_hi, input int exp_n, input int budget);
      int   n  = 1;
      int   hi = init_hi;
      int   lo = 0;
      int   k  = 0;
      logic prev = 1'b1;
      while ((bus.busy || bus.pulse_out) && k < budget) begin
         tick();
         k++;
         if (bus.pulse_out) begin
            if (!prev) begin
               chk("gap_width", lo, LOW_CYC);
               n++;
               hi = 0;
            end
            hi++;
         end else begin
            if (prev) begin
               chk("pulse_width", hi, HIGH_CYC);
               lo = 0;
            end
            lo++;
         end
         prev = bus.pulse_out;
      end
      chk("watch_in_budget", {31'd0, k < budget}, 1);
      chk("pulse_count", n, exp_n);
   endtask

   initial begin
      rst         = 1'b1;
      bus.evt_in  = 1'b0;
      bus.ovf_clr = 1'b0;
      tick();
      chk("rst_pulse", bus.pulse_out, 0);
      chk("rst_pending", bus.pending, 0);
      chk("rst_overflow", bus.overflow, 0);
      chk("rst_busy", bus.busy, 0);
      tick();
      rst = 1'b0;

      // Single event at edge 10
      wait_to(9);
      bus.evt_in = 1'b1; tick(); bus.evt_in = 1'b0;
      chk("s1_latency_pulse", bus.pulse_out, 1);
      chk("s1_pending", bus.pending, 0);
      wait_to(29);
      chk("s1_last_high", bus.pulse_out, 1);
      tick();
      chk("s1_first_low", bus.pulse_out, 0);
      chk("s1_pending_end", bus.pending, 0);
      wait_to(49);
      chk("s1_busy_in_low", bus.busy, 1);
      tick();
      chk("s1_busy_idle", bus.busy, 0);

      // Three events two cycles apart
      wait_to(59);
      bus.evt_in = 1'b1; tick(); bus.evt_in = 1'b0;
      chk("s2_pulse", bus.pulse_out, 1);
      tick();
      bus.evt_in = 1'b1; tick(); bus.evt_in = 1'b0;
      chk("s2_pending1", bus.pending, 1);
      tick();
      bus.evt_in = 1'b1; tick(); bus.evt_in = 1'b0;
      chk("s2_pending2", bus.pending, 2);
      watch(5, 3, 2000);
      chk("s2_pending_end", bus.pending, 0);
      chk("s2_overflow", bus.overflow, 0);

      // Twenty back-to-back events: saturation, overflow, clear-vs-drop
      t = cyc + 5;
      wait_to(t - 1);
      bus.evt_in = 1'b1;
      repeat (16) tick();
      chk("s3_pending_full", bus.pending, 15);
      chk("s3_no_ovf_yet", bus.overflow, 0);
      tick();
      chk("s3_ovf_set", bus.overflow, 1);
      chk("s3_pending_hold", bus.pending, 15);
      repeat (2) tick();
      bus.ovf_clr = 1'b1;
      tick();
      bus.evt_in  = 1'b0;
      bus.ovf_clr = 1'b0;
      chk("s3_clr_vs_drop", bus.overflow, 1);
      chk("s3_pulse_high", bus.pulse_out, 1);
      watch(20, 16, 2000);
      chk("s3_ovf_sticky", bus.overflow, 1);
      chk("s3_pending_end", bus.pending, 0);

      // Event on the LOW->HIGH edge with pending=3
      t = cyc + 5;
      wait_to(t - 1);
      bus.evt_in = 1'b1; repeat (4) tick(); bus.evt_in = 1'b0;
      chk("s4_pending3", bus.pending, 3);
      wait_to(t + 39);
      chk("s4_low_before", bus.pulse_out, 0);
      chk("s4_pending_before", bus.pending, 3);
      bus.evt_in = 1'b1; tick(); bus.evt_in = 1'b0;
      chk("s4_rehigh", bus.pulse_out, 1);
      chk("s4_pending_hold", bus.pending, 3);
      watch(1, 4, 2000);
      chk("s4_pending_end", bus.pending, 0);
      chk("s4_ovf_still", bus.overflow, 1);
      bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0;
      chk("ovf_cleared", bus.overflow, 0);

      // Slow receiver totals: 1 + 3 + 16 + 5 accepted events
      repeat (20) tick();
      slow_en = 1'b0;
      chk("slow_pulse_count", slow_pulses, 25);
      chk("slow_min_run_ge2", {31'd0, min_run >= 2}, 1);

      // Reset mid-pulse with pending=5, evt_in in the reset cycle
      t = cyc + 5;
      wait_to(t - 1);
      bus.evt_in = 1'b1; repeat (6) tick(); bus.evt_in = 1'b0;
      chk("s5_pending5", bus.pending, 5);
      wait_to(t + 7);
      chk("s5_mid_pulse", bus.pulse_out, 1);
      rst = 1'b1; bus.evt_in = 1'b1; tick(); rst = 1'b0; bus.evt_in = 1'b0;
      chk("s5_pulse_cut", bus.pulse_out, 0);
      chk("s5_pending_clr", bus.pending, 0);
      chk("s5_overflow_clr", bus.overflow, 0);
      chk("s5_busy_clr", bus.busy, 0);
      nhigh = 0;
      repeat (100) begin
         tick();
         if (bus.pulse_out) nhigh++;
      end
      chk("s5_no_more_pulses", nhigh, 0);
      chk("s5_busy_idle", bus.busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
